apb_completer_mem: RTL and testbench
====================================

// Module: apb_completer_mem
// PURPOSE
//  APB4 completer (responder) terminating the bridge's APB side: word-addressed register memory with
//  PSTRB byte-lane writes, fixed programmable wait states, PSLVERR on illegal accesses.
//  Sits on the APB bus as the target of the AHB-to-APB bridge and is the bridge bench's reference slave.
// PARAMETERS
//  ADDR_W      32          PADDR width
//  DATA_W      32          PWDATA/PRDATA width; byte lanes = DATA_W/8
//  DEPTH       16          number of DATA_W words
//  BASE_ADDR   32'h0000_0000  first decoded byte address; aligned to DEPTH*DATA_W/8
//  WAIT_CYCLES 0           ACCESS-phase wait states inserted before PREADY (0..15)
// PORTS
//  PCLK     in   1         APB clock
//  PRESETn  in   1         asynchronous active-low reset
//  PADDR    in   ADDR_W    byte address
//  PSEL     in   1         completer select
//  PENABLE  in   1         access phase
//  PPROT    in   3         protection attributes
//  PSTRB    in   DATA_W/8  write byte strobes
//  PWRITE   in   1         1 = write, 0 = read
//  PWDATA   in   DATA_W    write data
//  PRDATA   out  DATA_W    read data, valid only while PREADY=1 and PWRITE=0
//  PREADY   out  1         transfer completes this cycle
//  PSLVERR  out  1         error response, valid only while PREADY=1
// BEHAVIOUR
//  Reset (PRESETn=0, async): state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all words=0.
//  FSM: IDLE -(PSEL & !PENABLE)-> SETUP; SETUP -> ACCESS (always). In SETUP: latch PADDR/PWRITE/PSTRB/PWDATA/PPROT,
//    load counter=WAIT_CYCLES, evaluate error. ACCESS: counter!=0 -> decrement, PREADY=0;
//    counter==0 -> PREADY=1 for exactly one cycle, then -> SETUP if PSEL & !PENABLE, else IDLE.
//  Registered outputs: PREADY/PSLVERR/PRDATA are driven from flops; they are 0 in every cycle except the completing one.
//  Latency: 2 + WAIT_CYCLES cycles from SETUP to completion; back-to-back transfers have no idle gap.
//  Error (PSLVERR=1 with PREADY) when: latched address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8);
//    address not word-aligned; read with PSTRB!=0. Errored writes do not modify memory; errored reads return PRDATA=0.
//  Write commits on the completing cycle only; byte lane i updated iff PSTRB[i]. PSTRB=0 write: legal, no change.
//  Word index = (addr-BASE_ADDR) >> log2(DATA_W/8); out-of-range is never used to index storage.
//  PSEL deasserted in ACCESS before PREADY: abort -> IDLE, no write, PREADY stays 0.
//  PENABLE=1 seen in IDLE (no SETUP): ignored, remain IDLE, no response.
//  PADDR/PWDATA changes during ACCESS: ignored (latched values used).
//  Reset asserted mid-transfer: transfer discarded, memory cleared, outputs to reset values immediately.
// CONFIGURATION
//  APB_COMPLETER_PROT_CHECK_EN defined: a transfer with PPROT[0]=0 (unprivileged) to word index 0
//    gets PSLVERR=1 and is not performed; all other PPROT values are treated as normal.
//  Not defined: PPROT is ignored and never causes PSLVERR.
// STRUCTURE
//  Package apb_completer_pkg: state enum {IDLE,SETUP,ACCESS}; err_e {ERR_NONE,ERR_RANGE,ERR_ALIGN,ERR_RDSTRB,ERR_PROT};
//    localparam helpers STRB_W(DATA_W), IDX_W(DEPTH).
//  Sub-module apb_completer_regfile: DEPTH x DATA_W storage, byte-enable write port, async-read port,
//    async clear on PRESETn. Top holds the FSM, wait counter, decode and error logic.
// TESTING
//  1 WAIT_CYCLES=0: write 32'hDEAD_BEEF to 0x04 PSTRB=4'hF, read 0x04 -> PREADY in first ACCESS cycle,
//    PRDATA=32'hDEAD_BEEF, PSLVERR=0.
//  2 WAIT_CYCLES=3: read 0x00 -> PREADY low for 3 ACCESS cycles, high on 4th; PRDATA=0 after reset.
//  3 Byte lanes: write 32'h1122_3344 PSTRB=4'hF then 32'hAABB_CCDD PSTRB=4'b0101 to 0x08 -> reads 32'h11BB_33DD.
//  4 Errors: write 0x40 (DEPTH=16), write 0x02, read 0x00 with PSTRB=4'h1 -> each PSLVERR=1 with PREADY;
//    subsequent readback shows memory unchanged.
//  5 Abort/reset: WAIT_CYCLES=2, drop PSEL in 1st ACCESS cycle of write to 0x0C -> no PREADY, 0x0C still 0;
//    assert PRESETn=0 mid-transfer -> PREADY/PSLVERR/PRDATA=0 same cycle, all words read 0 after release.
//  6 With APB_COMPLETER_PROT_CHECK_EN: write 0x00 PPROT=3'b000 -> PSLVERR=1, no write; PPROT=3'b001 -> succeeds.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// Shared types and sizing helpers for the APB completer memory.
package apb_completer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_RANGE  = 3'd1,
    ERR_ALIGN  = 3'd2,
    ERR_RDSTRB = 3'd3,
    ERR_PROT   = 3'd4
  } err_e;

  // Number of byte lanes on a data bus of the given width.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Word index width; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_completer_mem_if.sv
// APB4 bus bundle between a requester and the completer memory.
// Handshake: a transfer starts with PSEL=1/PENABLE=0 for one cycle (setup
// phase), then PENABLE=1 is held with all request fields stable until the
// completer returns PREADY=1; PRDATA and PSLVERR are meaningful only in that
// PREADY=1 cycle, which ends the transfer.
interface apb_completer_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   PADDR;
  logic                PSEL;
  logic                PENABLE;
  logic [2:0]          PPROT;
  logic [DATA_W/8-1:0] PSTRB;
  logic                PWRITE;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PPROT, PSTRB, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PPROT, PSTRB, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_completer_regfile.sv
// Word storage with a byte-enable write port and an asynchronous read port.
// Every word is cleared asynchronously while rst_n is low.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int STRB_W = strb_w(DATA_W),
  localparam int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear on reset; otherwise update only the strobed byte lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer with word-addressed register memory, byte-lane writes,
// fixed wait states and PSLVERR on illegal accesses.
// Optional: define APB_COMPLETER_PROT_CHECK_EN to reject unprivileged
// (PPROT[0]=0) accesses to word 0.
// The FSM sees the bus setup phase while in IDLE; SETUP is the first
// PENABLE cycle (request latched at its end), ACCESS counts wait states.
module apb_completer_mem
  import apb_completer_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  apb_completer_mem_if.slave        apb,
  output state_e                    dbg_state
);

  localparam int                STRB_W  = strb_w(DATA_W);
  localparam int                IDX_W   = idx_w(DEPTH);
  localparam int                OFF_B   = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(DEPTH * STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(STRB_W - 1);
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [IDX_W-1:0]    idx_q;
  err_e                err_q;
  logic                pready_q, pslverr_q;
  logic [DATA_W-1:0]   prdata_q;

  logic [ADDR_W-1:0]   offset;
  logic                in_range, aligned;
  logic [IDX_W-1:0]    idx_bus;
  err_e                err_bus;
  logic                cur_write;
  err_e                cur_err;
  logic [IDX_W-1:0]    cur_idx;
  logic                complete_d;
  logic                mem_we;
  logic [DATA_W-1:0]   rd_data;

  // Address decode straight off the bus; the index is forced to 0 when the
  // address is out of range so storage is never indexed by garbage.
  always_comb begin
    offset   = apb.PADDR - BASE_ADDR;
    in_range = (apb.PADDR >= BASE_ADDR) && (offset < SPAN);
    aligned  = (apb.PADDR & ALIGN_M) == '0;
    idx_bus  = in_range ? offset[OFF_B +: IDX_W] : '0;
  end

  // Error classification of the request being latched, first cause wins.
  always_comb begin
    err_bus = ERR_NONE;
    if (!in_range)                          err_bus = ERR_RANGE;
    else if (!aligned)                      err_bus = ERR_ALIGN;
    else if (!apb.PWRITE && apb.PSTRB != '0) err_bus = ERR_RDSTRB;
`ifdef APB_COMPLETER_PROT_CHECK_EN
    else if (!apb.PPROT[0] && idx_bus == '0) err_bus = ERR_PROT;
`endif
  end

`ifndef APB_COMPLETER_PROT_CHECK_EN
  logic unused_pprot;
  assign unused_pprot = ^apb.PPROT;
`endif

  // Next state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LD;
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          if (!apb.PSEL) state_d = IDLE;
          else           cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = (apb.PSEL && !apb.PENABLE) ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request view for the response flops: the bus while it is being latched,
  // the latched copy afterwards.
  always_comb begin
    cur_write  = (state_q == SETUP) ? apb.PWRITE : write_q;
    cur_err    = (state_q == SETUP) ? err_bus    : err_q;
    cur_idx    = (state_q == SETUP) ? idx_bus    : idx_q;
    complete_d = (state_d == ACCESS) && (cnt_d == 4'd0);
    mem_we     = (state_q == ACCESS) && (cnt_q == 4'd0) && write_q && (err_q == ERR_NONE);
  end

  // State register and wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at the end of SETUP; later bus changes are ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      write_q <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      err_q   <= ERR_NONE;
    end else if (state_q == SETUP) begin
      write_q <= apb.PWRITE;
      strb_q  <= apb.PSTRB;
      wdata_q <= apb.PWDATA;
      idx_q   <= idx_bus;
      err_q   <= err_bus;
    end
  end

  // Registered response, nonzero only in the completing cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= complete_d;
      pslverr_q <= complete_d && (cur_err != ERR_NONE);
      prdata_q  <= (complete_d && !cur_write && cur_err == ERR_NONE) ? rd_data : '0;
    end
  end

  apb_completer_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .widx  (idx_q),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .ridx  (cur_idx),
    .rdata (rd_data)
  );

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem: three instances with 0, 3 and 2 wait
// states share one set of driven request signals; only the selected
// instance sees PSEL. Build with APB_COMPLETER_PROT_CHECK_EN defined to
// exercise the protection check branch.
module tb_apb_completer_mem;
  import apb_completer_pkg::*;

  localparam logic [2:0] PRIV = 3'b001;

  logic        pclk;
  logic        prst_n;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  int          sel;

  logic [31:0] obs_prdata;
  logic        obs_ready, obs_slverr;
  state_e      obs_state, st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  apb_completer_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_completer_mem_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  apb_completer_mem_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  assign bus0.PADDR = paddr;  assign bus1.PADDR = paddr;  assign bus2.PADDR = paddr;
  assign bus0.PENABLE = penable; assign bus1.PENABLE = penable; assign bus2.PENABLE = penable;
  assign bus0.PPROT = pprot;  assign bus1.PPROT = pprot;  assign bus2.PPROT = pprot;
  assign bus0.PSTRB = pstrb;  assign bus1.PSTRB = pstrb;  assign bus2.PSTRB = pstrb;
  assign bus0.PWRITE = pwrite; assign bus1.PWRITE = pwrite; assign bus2.PWRITE = pwrite;
  assign bus0.PWDATA = pwdata; assign bus1.PWDATA = pwdata; assign bus2.PWDATA = pwdata;
  assign bus0.PSEL = psel && (sel == 0);
  assign bus1.PSEL = psel && (sel == 1);
  assign bus2.PSEL = psel && (sel == 2);

  apb_completer_mem #(.WAIT_CYCLES(0)) u_w0 (.PCLK(pclk), .PRESETn(prst_n), .apb(bus0), .dbg_state(st0));
  apb_completer_mem #(.WAIT_CYCLES(3)) u_w3 (.PCLK(pclk), .PRESETn(prst_n), .apb(bus1), .dbg_state(st1));
  apb_completer_mem #(.WAIT_CYCLES(2)) u_w2 (.PCLK(pclk), .PRESETn(prst_n), .apb(bus2), .dbg_state(st2));

  always_comb begin
    obs_prdata = bus0.PRDATA;
    obs_ready  = bus0.PREADY;
    obs_slverr = bus0.PSLVERR;
    obs_state  = st0;
    case (sel)
      1: begin
        obs_prdata = bus1.PRDATA; obs_ready = bus1.PREADY;
        obs_slverr = bus1.PSLVERR; obs_state = st1;
      end
      2: begin
        obs_prdata = bus2.PRDATA; obs_ready = bus2.PREADY;
        obs_slverr = bus2.PSLVERR; obs_state = st2;
      end
      default: ;
    endcase
  end

  // Clock and reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer to the selected instance. waits counts the
  // PENABLE cycles seen before PREADY. With scramble set, PADDR/PWDATA are
  // changed once the request is already held by the completer.
  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                          input bit scramble, output logic [31:0] rdata, output logic slverr,
                          output int waits);
    bit done;
    done   = 1'b0;
    waits  = 0;
    rdata  = '0;
    slverr = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pwdata = wd; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (obs_ready) begin
        done   = 1'b1;
        rdata  = obs_prdata;
        slverr = obs_slverr;
      end else begin
        waits++;
        if (scramble && i == 1) begin
          paddr  = addr ^ 32'h4;
          pwdata = ~wd;
        end
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    pwdata = $urandom; paddr = $urandom_range(0, 255);
    @(negedge pclk);
    chk({tag, "_ready_one_cycle"}, 32'(obs_ready), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [2:0] prot, input logic exp_err,
                          input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(tag, 1'b1, addr, wd, strb, prot, 1'b0, rd, err, w);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_waits"}, w, exp_waits);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(tag, 1'b0, addr, 32'h0, strb, PRIV, 1'b0, rd, err, w);
    chk({tag, "_prdata"}, rd, exp_data);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_waits"}, w, exp_waits);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    bit          saw_ready;

    prst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = PRIV; sel = 0;
    repeat (3) @(posedge pclk);

    // Reset values on every instance
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk($sformatf("rst_ready_%0d", s), 32'(obs_ready), 32'd0);
      chk($sformatf("rst_slverr_%0d", s), 32'(obs_slverr), 32'd0);
      chk($sformatf("rst_prdata_%0d", s), obs_prdata, 32'd0);
      chk($sformatf("rst_state_%0d", s), 32'(obs_state), 32'(IDLE));
    end
    @(negedge pclk); prst_n = 1'b1;
    sel = 0;

    // Zero wait states: PREADY on the second PENABLE cycle
    do_write("w0_wr04", 32'h04, 32'hDEAD_BEEF, 4'hF, PRIV, 1'b0, 1);
    do_read ("w0_rd04", 32'h04, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);

    // PENABLE without a setup phase is ignored
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0; pstrb = 4'hF;
    saw_ready = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (obs_ready) saw_ready = 1'b1;
    end
    chk("idle_penable_ready", 32'(saw_ready), 32'd0);
    chk("idle_penable_state", 32'(obs_state), 32'(IDLE));
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    do_read("idle_penable_rd04", 32'h04, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);

    // Three wait states: PREADY after four low PENABLE cycles, memory reset to 0
    sel = 1;
    do_read("w3_rd00", 32'h00, 4'h0, 32'h0, 1'b0, 4);
    // Request fields changed mid-transfer must be ignored
    apb_xfer("w3_scramble", 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, PRIV, 1'b1, rd, err, w);
    chk("w3_scramble_pslverr", 32'(err), 32'd0);
    do_read("w3_rd10", 32'h10, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
    do_read("w3_rd14", 32'h14, 4'h0, 32'h0, 1'b0, 4);

    // Byte lanes
    sel = 0;
    do_write("lane_full", 32'h08, 32'h1122_3344, 4'hF, PRIV, 1'b0, 1);
    do_write("lane_part", 32'h08, 32'hAABB_CCDD, 4'b0101, PRIV, 1'b0, 1);
    do_read ("lane_rd08", 32'h08, 4'h0, 32'h11BB_33DD, 1'b0, 1);
    do_write("strb0_wr04", 32'h04, 32'h0123_4567, 4'h0, PRIV, 1'b0, 1);
    do_read ("strb0_rd04", 32'h04, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);
    do_write("last_wr3c", 32'h3C, 32'h5A5A_A5A5, 4'hF, PRIV, 1'b0, 1);
    do_read ("last_rd3c", 32'h3C, 4'h0, 32'h5A5A_A5A5, 1'b0, 1);

    // Error responses leave memory untouched
    do_write("err_range_wr40", 32'h40, 32'hBAD0_BAD0, 4'hF, PRIV, 1'b1, 1);
    do_write("err_align_wr02", 32'h02, 32'hBAD1_BAD1, 4'hF, PRIV, 1'b1, 1);
    do_read ("err_rdstrb_rd00", 32'h00, 4'h1, 32'h0, 1'b1, 1);
    do_read ("err_range_rd44", 32'h44, 4'h0, 32'h0, 1'b1, 1);
    do_read ("err_range_rd3c_hi", 32'h0000_103C, 4'h0, 32'h0, 1'b1, 1);
    do_read ("post_err_rd00", 32'h00, 4'h0, 32'h0, 1'b0, 1);
    do_read ("post_err_rd04", 32'h04, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);

    // Abort: PSEL dropped in the first counting cycle of a two-wait write
    sel = 2;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
    pwdata = 32'h7777_8888; pstrb = 4'hF; pprot = PRIV;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    saw_ready = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (obs_ready) saw_ready = 1'b1;
    end
    chk("abort_ready", 32'(saw_ready), 32'd0);
    chk("abort_state", 32'(obs_state), 32'(IDLE));
    do_read("abort_rd0c", 32'h0C, 4'h0, 32'h0, 1'b0, 3);

    // Reset asserted inside the completing cycle of a read
    sel = 0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h04; pwrite = 1'b0; pstrb = 4'h0;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    chk("midrst_pre_ready", 32'(obs_ready), 32'd1);
    chk("midrst_pre_prdata", obs_prdata, 32'hDEAD_BEEF);
    #1 prst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(obs_ready), 32'd0);
    chk("midrst_slverr", 32'(obs_slverr), 32'd0);
    chk("midrst_prdata", obs_prdata, 32'd0);
    chk("midrst_state", 32'(obs_state), 32'(IDLE));
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk); prst_n = 1'b1;
    do_read("postrst_rd04", 32'h04, 4'h0, 32'h0, 1'b0, 1);
    do_read("postrst_rd08", 32'h08, 4'h0, 32'h0, 1'b0, 1);
    do_read("postrst_rd3c", 32'h3C, 4'h0, 32'h0, 1'b0, 1);
    sel = 1;
    do_read("postrst_w3_rd10", 32'h10, 4'h0, 32'h0, 1'b0, 4);

    // Protection attribute on word 0
    sel = 0;
`ifdef APB_COMPLETER_PROT_CHECK_EN
    do_write("prot_unpriv_wr00", 32'h00, 32'h1234_5678, 4'hF, 3'b000, 1'b1, 1);
    do_read ("prot_unpriv_rd00", 32'h00, 4'h0, 32'h0, 1'b0, 1);
    do_write("prot_priv_wr00", 32'h00, 32'h1234_5678, 4'hF, 3'b001, 1'b0, 1);
    do_read ("prot_priv_rd00", 32'h00, 4'h0, 32'h1234_5678, 1'b0, 1);
    do_write("prot_unpriv_wr04", 32'h04, 32'h9ABC_DEF0, 4'hF, 3'b000, 1'b0, 1);
    do_read ("prot_unpriv_rd04", 32'h04, 4'h0, 32'h9ABC_DEF0, 1'b0, 1);
`else
    do_write("prot_ignored_wr00", 32'h00, 32'h1234_5678, 4'hF, 3'b000, 1'b0, 1);
    do_read ("prot_ignored_rd00", 32'h00, 4'h0, 32'h1234_5678, 1'b0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
